// File: rtl/led_pattern_scheduler.sv
// Mode/speed/pause sequencer for the 16-LED flow bank, driven by three raw buttons.
// Optional auto mode advance after AUTO_TICKS steps: define LED_AUTO_MODE_EN.
module led_pattern_scheduler #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BASE_CNT   = 12_500_000,
  parameter int AUTO_TICKS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_speed,
  input  logic        btn_pause,
  output logic [15:0] led,
  output logic [1:0]  mode,
  output logic [1:0]  speed,
  output logic        paused,
  output logic        tick
);

  typedef enum logic [1:0] {SHIFT_L, SHIFT_R, PINGPONG, BLINK} mode_t;
  typedef enum logic {LEFT, RIGHT} dir_t;

  if (BASE_CNT < 1 || 64'(BASE_CNT) * 64'd8 >= 64'h1_0000_0000 || AUTO_TICKS < 1 || CLK_FREQ < 1)
  begin : g_bad_params
    $error("led_pattern_scheduler: invalid parameter set");
  end

  // Bit order of the button vectors: 0 mode, 1 speed, 2 pause.
  logic [2:0] btn_raw;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic [2:0] prev_reg;
  logic [2:0] btn_event;

  assign btn_raw = {btn_pause, btn_speed, btn_mode};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_reg[gi] <= 1'b0;
        sync2_reg[gi] <= 1'b0;
        prev_reg[gi]  <= 1'b0;
      end else begin
        sync1_reg[gi] <= btn_raw[gi];
        sync2_reg[gi] <= sync1_reg[gi];
        prev_reg[gi]  <= sync2_reg[gi];
      end
    end
    assign btn_event[gi] = prev_reg[gi] & ~sync2_reg[gi];
  end

  logic [15:0] led_reg,    led_next;
  mode_t       mode_reg,   mode_next;
  logic [1:0]  speed_reg,  speed_next;
  logic        paused_reg, paused_next;
  logic        tick_reg,   tick_next;
  logic [31:0] cnt_reg,    cnt_next;
  dir_t        dir_reg,    dir_next;
  logic [31:0] period;
  logic        wrap;
  logic        auto_adv;
`ifdef LED_AUTO_MODE_EN
  logic [31:0] tick_cnt_reg, tick_cnt_next;
`endif

  always_comb begin
    led_next    = led_reg;
    mode_next   = mode_reg;
    speed_next  = speed_reg;
    paused_next = paused_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    period      = 32'(BASE_CNT) << speed_reg;
    wrap        = !paused_reg && (cnt_reg == period - 32'd1);
    // A button mode/speed event steals the wrap: no tick, no step.
    tick_next   = wrap && !btn_event[0] && !btn_event[1];

    if (btn_event[2]) paused_next = ~paused_reg;
    if (btn_event[1]) speed_next = speed_reg + 2'd1;

    if (btn_event[0] || btn_event[1]) cnt_next = '0;
    else if (!paused_reg) cnt_next = wrap ? 32'd0 : cnt_reg + 32'd1;

`ifdef LED_AUTO_MODE_EN
    tick_cnt_next = tick_cnt_reg;
    auto_adv      = tick_next && (tick_cnt_reg == 32'(AUTO_TICKS - 1));
    if (btn_event[0] || auto_adv) tick_cnt_next = '0;
    else if (tick_next) tick_cnt_next = tick_cnt_reg + 32'd1;
`else
    auto_adv = 1'b0;
`endif

    if (btn_event[0] || auto_adv) begin
      mode_next = mode_t'(mode_reg + 2'd1);
      dir_next  = LEFT;
      case (mode_next)
        SHIFT_L:  led_next = 16'h0001;
        SHIFT_R:  led_next = 16'h8000;
        PINGPONG: led_next = 16'h0001;
        default:  led_next = 16'hFFFF;
      endcase
    end else if (tick_next) begin
      case (mode_reg)
        SHIFT_L:  led_next = {led_reg[14:0], led_reg[15]};
        SHIFT_R:  led_next = {led_reg[0], led_reg[15:1]};
        PINGPONG: begin
          // Direction flips one step before the end so 8000/0001 appear once per sweep.
          if (dir_reg == LEFT) begin
            led_next = led_reg << 1;
            if (led_reg == 16'h4000) dir_next = RIGHT;
          end else begin
            led_next = led_reg >> 1;
            if (led_reg == 16'h0002) dir_next = LEFT;
          end
        end
        default:  led_next = ~led_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg    <= 16'h0001;
      mode_reg   <= SHIFT_L;
      speed_reg  <= 2'd2;
      paused_reg <= 1'b0;
      tick_reg   <= 1'b0;
      cnt_reg    <= '0;
      dir_reg    <= LEFT;
    end else begin
      led_reg    <= led_next;
      mode_reg   <= mode_next;
      speed_reg  <= speed_next;
      paused_reg <= paused_next;
      tick_reg   <= tick_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
    end
  end

`ifdef LED_AUTO_MODE_EN
  always_ff @(posedge clk) begin
    if (rst) tick_cnt_reg <= '0;
    else     tick_cnt_reg <= tick_cnt_next;
  end
`endif

  assign led    = led_reg;
  assign mode   = mode_reg;
  assign speed  = speed_reg;
  assign paused = paused_reg;
  assign tick   = tick_reg;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Randomized scoreboard bench for led_pattern_scheduler with a pattern-index reference model.
module tb_led_pattern_scheduler;
  localparam int BASE = 4;
  localparam int AUTO = 3;
  localparam logic [15:0] SEED [4] = '{16'h0001, 16'h8000, 16'h0001, 16'hFFFF};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_mode = 1'b0, btn_speed = 1'b0, btn_pause = 1'b0;
  logic [15:0] led;
  logic [1:0]  mode, speed;
  logic        paused, tick;

  led_pattern_scheduler #(.BASE_CNT(BASE), .AUTO_TICKS(AUTO)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_speed(btn_speed),
    .btn_pause(btn_pause), .led(led), .mode(mode), .speed(speed),
    .paused(paused), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint      t;
    logic [15:0] led;
    logic [1:0]  mode;
    logic [1:0]  speed;
    logic        paused;
    logic        tick;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  // Reference model state; pingpong tracked as a position in its 30-step cycle.
  logic [15:0] m_led = 16'h0001;
  logic [1:0]  m_mode = 2'd0, m_speed = 2'd2;
  bit          m_paused = 1'b0;
  longint      m_cnt = 0;
  int          m_pp = 0;
  int          m_tc = 0;
  logic [2:0]  h0 = '0, h1 = '0, h2 = '0;   // raw samples 1, 2, 3 edges ago

  task automatic model_edge(input bit r, input logic [2:0] raw);
    logic [2:0] ev;
    logic [1:0] pm, ps;
    bit         pp, tk, wrap, adv;
    longint     period;
    rec_t       e;
    pm = m_mode; ps = m_speed; pp = m_paused; tk = 1'b0;
    if (r) begin
      m_led = 16'h0001; m_mode = 2'd0; m_speed = 2'd2; m_paused = 1'b0;
      m_cnt = 0; m_pp = 0; m_tc = 0;
      h0 = '0; h1 = '0; h2 = '0;
    end else begin
      ev = ~h1 & h2;                       // level fell three edges ago
      period = longint'(BASE) << m_speed;
      wrap = !m_paused && (m_cnt == period - 1);
      tk = wrap && !ev[0] && !ev[1];
      if (ev[0] || ev[1]) m_cnt = 0;
      else if (!m_paused) m_cnt = wrap ? 0 : m_cnt + 1;
      if (ev[2]) m_paused = !m_paused;
      if (ev[1]) m_speed = m_speed + 2'd1;
      adv = ev[0];
`ifdef LED_AUTO_MODE_EN
      if (tk) begin
        m_tc++;
        if (m_tc == AUTO) adv = 1'b1;
      end
      if (adv) m_tc = 0;
`endif
      if (adv) begin
        m_mode = m_mode + 2'd1;
        m_pp = 0;
        m_led = SEED[m_mode];
      end else if (tk) begin
        case (m_mode)
          2'd0: m_led = {m_led[14:0], m_led[15]};
          2'd1: m_led = {m_led[0], m_led[15:1]};
          2'd2: begin
            m_pp = (m_pp + 1) % 30;
            m_led = 16'd1 << ((m_pp < 16) ? m_pp : 30 - m_pp);
          end
          default: m_led = ~m_led;
        endcase
      end
      h2 = h1; h1 = h0; h0 = raw;
    end
    if (mon_en && (tk || pm != m_mode || ps != m_speed || pp != m_paused)) begin
      e.t = longint'($time); e.led = m_led; e.mode = m_mode; e.speed = m_speed;
      e.paused = m_paused; e.tick = tk;
      exp_q.push_back(e);
    end
  endtask

  logic [2:0] raw = '0;   // {pause, speed, mode}

  task automatic cyc(input bit r);
    rst = r;
    {btn_pause, btn_speed, btn_mode} = raw;
    @(posedge clk);
    model_edge(r, raw);
    #1;
  endtask

  task automatic press(input int idx, input int idle);
    raw[idx] = 1'b1;
    repeat (2) cyc(1'b0);
    raw[idx] = 1'b0;
    repeat (idle) cyc(1'b0);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: a transaction is any tick or any change of mode/speed/paused.
  initial begin
    logic [1:0] pmode, pspeed;
    logic       ppaused;
    bit         started;
    rec_t       e;
    started = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!started) begin
          started = 1'b1;
        end else if (tick !== 1'b0 || mode !== pmode || speed !== pspeed || paused !== ppaused) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output t=%0d: got led=%h mode=%0d speed=%0d paused=%0b tick=%0b, expected no transaction",
                     longint'($time) - 5, led, mode, speed, paused, tick);
          end else begin
            e = exp_q.pop_front();
            if (e.t != longint'($time) - 5 || e.led !== led || e.mode !== mode ||
                e.speed !== speed || e.paused !== paused || e.tick !== tick) begin
              n_bad++;
              $display("FAIL transaction t=%0d: got led=%h mode=%0d speed=%0d paused=%0b tick=%0b, expected t=%0d led=%h mode=%0d speed=%0d paused=%0b tick=%0b",
                       longint'($time) - 5, led, mode, speed, paused, tick,
                       e.t, e.led, e.mode, e.speed, e.paused, e.tick);
            end else begin
              $display("ok t=%0d led=%h mode=%0d speed=%0d paused=%0b tick=%0b",
                       e.t, led, mode, speed, paused, tick);
            end
          end
        end
        pmode = mode; pspeed = speed; ppaused = paused;
      end
    end
  end

  initial begin
    repeat (3) cyc(1'b1);
    chk("reset_led", led, 16'h0001);
    chk("reset_mode", 16'(mode), 16'd0);
    chk("reset_speed", 16'(speed), 16'd2);
    chk("reset_paused", 16'(paused), 16'd0);
    chk("reset_tick", 16'(tick), 16'd0);
    mon_en = 1'b1;

    repeat (70) cyc(1'b0);
    chk("idle_led_after_70", led, 16'h0010);
    press(1, 20);
    press(1, 20);
    press(0, 10);
    press(0, 10);
    press(0, 30);
    chk("blink_mode", 16'(mode), 16'd3);
    press(0, 5);
    press(0, 5);
    press(0, 31 * 4 + 10);
    press(2, 100);
    chk("paused_hold", 16'(paused), 16'd1);
    press(2, 20);

    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(39) == 0) raw[b] = ~raw[b];
      if ($urandom_range(1499) == 0) begin
        cyc(1'b1);
        chk("midrun_reset_led", led, 16'h0001);
        chk("midrun_reset_speed", 16'(speed), 16'd2);
      end else begin
        cyc(1'b0);
      end
    end

    raw = '0;
    repeat (40) cyc(1'b0);
    #10;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_output: got %0d transactions still pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
